// File: rtl/i2s_rx_if.sv
// Signal bundle between an I2S transmitter or pin driver (master) and the i2s_rx deserializer (slave).
interface i2s_rx_if #(
    parameter int unsigned DATA_W = 16
);
    logic              sclk;
    logic              ws;
    logic              sd;
    logic [DATA_W-1:0] data_out;
    logic              data_right;
    logic              data_valid;
    logic              short_err;
    logic [7:0]        err_count;

    modport master (
        output sclk, ws, sd,
        input  data_out, data_right, data_valid, short_err, err_count
    );

    modport slave (
        input  sclk, ws, sd,
        output data_out, data_right, data_valid, short_err, err_count
    );
endinterface

// File: rtl/i2s_rx.sv
// I2S receiver: oversamples sclk/ws/sd in the clk domain and emits one tagged word per channel slot.
// Optional saturating short-slot counter is built when I2S_RX_ERRCNT_EN is defined.
module i2s_rx #(
    parameter int unsigned DATA_W      = 16,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic    clk,
    input  logic    reset_n,
    i2s_rx_if.slave bus
);
    localparam int unsigned CW = $clog2(DATA_W + 1);

    // IDLE: no ws reference yet; WAIT: ws reference held, no boundary seen; SYNC: framing known
    typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_SYNC} state_t;

    logic [SYNC_STAGES-1:0] sclk_sync_q, ws_sync_q, sd_sync_q;
    logic                   sclk_prev_q, strobe_q, ws_r_q, sd_r_q;
    logic                   sclk_s, ws_s, sd_s;

    state_t            state_q, state_d;
    logic              chan_q, chan_d;
    logic              ws_p_q, ws_p_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic [DATA_W-1:0] data_out_q, data_out_d;
    logic              data_right_q, data_right_d;
    logic              valid_q, valid_d;
    logic              short_q, short_d;

    assign sclk_s = sclk_sync_q[SYNC_STAGES-1];
    assign ws_s   = ws_sync_q[SYNC_STAGES-1];
    assign sd_s   = sd_sync_q[SYNC_STAGES-1];

    // ws/sd ride through the same pipeline as sclk so they stay aligned with the strobe
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sclk_sync_q <= '0;
            ws_sync_q   <= '0;
            sd_sync_q   <= '0;
            sclk_prev_q <= 1'b0;
            strobe_q    <= 1'b0;
            ws_r_q      <= 1'b0;
            sd_r_q      <= 1'b0;
        end else begin
            sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], bus.sclk};
            ws_sync_q   <= {ws_sync_q[SYNC_STAGES-2:0], bus.ws};
            sd_sync_q   <= {sd_sync_q[SYNC_STAGES-2:0], bus.sd};
            sclk_prev_q <= sclk_s;
            strobe_q    <= sclk_s & ~sclk_prev_q;
            ws_r_q      <= ws_s;
            sd_r_q      <= sd_s;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            chan_q       <= 1'b0;
            ws_p_q       <= 1'b0;
            cnt_q        <= '0;
            shift_q      <= '0;
            data_out_q   <= '0;
            data_right_q <= 1'b0;
            valid_q      <= 1'b0;
            short_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            chan_q       <= chan_d;
            ws_p_q       <= ws_p_d;
            cnt_q        <= cnt_d;
            shift_q      <= shift_d;
            data_out_q   <= data_out_d;
            data_right_q <= data_right_d;
            valid_q      <= valid_d;
            short_q      <= short_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        chan_d       = chan_q;
        ws_p_d       = ws_p_q;
        cnt_d        = cnt_q;
        shift_d      = shift_q;
        data_out_d   = data_out_q;
        data_right_d = data_right_q;
        valid_d      = 1'b0;
        short_d      = 1'b0;
        if (strobe_q) begin
            if (state_q == ST_SYNC && cnt_q < CW'(DATA_W)) begin
                shift_d = {shift_q[DATA_W-2:0], sd_r_q};
                cnt_d   = cnt_q + CW'(1);
                if (cnt_d == CW'(DATA_W)) begin
                    data_out_d   = shift_d;
                    data_right_d = chan_q;
                    valid_d      = 1'b1;
                end
            end
            ws_p_d = ws_r_q;
            // Boundary is judged after this strobe's bit, so an LSB sharing the ws edge still completes
            if (state_q == ST_IDLE) begin
                state_d = ST_WAIT;
            end else if (ws_r_q != ws_p_q) begin
                if (state_q == ST_SYNC && cnt_d < CW'(DATA_W)) begin
                    short_d = 1'b1;
                end
                state_d = ST_SYNC;
                chan_d  = ws_r_q;
                cnt_d   = '0;
                shift_d = '0;
            end
        end
    end

    assign bus.data_out   = data_out_q;
    assign bus.data_right = data_right_q;
    assign bus.data_valid = valid_q;
    assign bus.short_err  = short_q;

`ifdef I2S_RX_ERRCNT_EN
    logic [7:0] err_cnt_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            err_cnt_q <= '0;
        end else if (short_q && err_cnt_q != 8'hFF) begin
            err_cnt_q <= err_cnt_q + 8'd1;
        end
    end

    assign bus.err_count = err_cnt_q;
`else
    assign bus.err_count = '0;
`endif
endmodule

// File: tb/tb_i2s_rx.sv
// Directed bench for i2s_rx: drives I2S frames at 8 clk per bit and checks captured words, errors and latency.
module tb_i2s_rx;
    localparam int unsigned DATA_W      = 16;
    localparam int unsigned SYNC_STAGES = 2;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;

    i2s_rx_if #(.DATA_W(DATA_W)) bus ();

    i2s_rx #(.DATA_W(DATA_W), .SYNC_STAGES(SYNC_STAGES)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0] d;
        logic        r;
        logic [31:0] lat;
    } rec_t;

    rec_t recs[$];
    rec_t mon_rec;
    int   cyc        = 0;
    int   last_rise  = 0;
    int   err_seen   = 0;
    int   both_seen  = 0;
    int   n_cmp      = 0;
    int   n_bad      = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (bus.data_valid === 1'b1) begin
            mon_rec.d   = bus.data_out;
            mon_rec.r   = bus.data_right;
            mon_rec.lat = cyc - last_rise;
            recs.push_back(mon_rec);
        end
        if (bus.short_err === 1'b1) err_seen++;
        if (bus.data_valid === 1'b1 && bus.short_err === 1'b1) both_seen++;
    end

    // One sclk period: 4 clk low then 4 clk high; ws/sd change on the falling edge.
    task automatic send_bit(input logic w, input logic d);
        bus.sclk = 1'b0;
        bus.ws   = w;
        bus.sd   = d;
        repeat (4) @(posedge clk);
        #1;
        bus.sclk  = 1'b1;
        last_rise = cyc;
        repeat (4) @(posedge clk);
        #1;
    endtask

    // MSB first; the last bit carries the next slot's ws, as in standard I2S.
    task automatic send_slot(input logic ch, input logic [31:0] w, input int unsigned width, input logic nxt);
        for (int unsigned i = 0; i < width; i++)
            send_bit((i == width - 1) ? nxt : ch, w[width-1-i]);
    endtask

    task automatic idle(input int unsigned n);
        bus.sclk = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        bus.sclk = 1'b0;
        bus.ws   = 1'b0;
        bus.sd   = 1'b0;
        reset_n  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        bus.sclk = 1'b0;
        bus.ws   = 1'b0;
        bus.sd   = 1'b0;
        reset_n  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++; if (bus.data_out !== 16'h0000) begin n_bad++; $display("FAIL reset_data_out: got %h want 0000", bus.data_out); end
        n_cmp++; if (bus.data_right !== 1'b0) begin n_bad++; $display("FAIL reset_data_right: got %b want 0", bus.data_right); end
        n_cmp++; if (bus.data_valid !== 1'b0) begin n_bad++; $display("FAIL reset_data_valid: got %b want 0", bus.data_valid); end
        n_cmp++; if (bus.short_err !== 1'b0) begin n_bad++; $display("FAIL reset_short_err: got %b want 0", bus.short_err); end
        n_cmp++; if (bus.err_count !== 8'h00) begin n_bad++; $display("FAIL reset_err_count: got %h want 00", bus.err_count); end
        reset_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_presync();
        int base;
        int e0;
        base = recs.size();
        e0   = err_seen;
        for (int i = 0; i < 20; i++) send_bit(1'b0, 1'(i % 2));
        idle(8);
        n_cmp++; if (recs.size() !== base) begin n_bad++; $display("FAIL presync_no_valid: got %0d words want 0", recs.size() - base); end
        n_cmp++; if (err_seen !== e0) begin n_bad++; $display("FAIL presync_no_err: got %0d errors want 0", err_seen - e0); end
        send_bit(1'b1, 1'b1);
        send_slot(1'b1, 32'h0000_C0DE, 16, 1'b0);
        idle(8);
        n_cmp++; if (recs.size() !== base + 1) begin n_bad++; $display("FAIL presync_count: got %0d words want 1", recs.size() - base); end
        n_cmp++; if (recs[base].d !== 16'hC0DE) begin n_bad++; $display("FAIL presync_data: got %h want c0de", recs[base].d); end
        n_cmp++; if (recs[base].r !== 1'b1) begin n_bad++; $display("FAIL presync_right: got %b want 1", recs[base].r); end
    endtask

    task automatic test_standard();
        int base;
        int e0;
        do_reset();
        base = recs.size();
        e0   = err_seen;
        send_slot(1'b1, 32'h0000_0000, 16, 1'b0);
        send_slot(1'b0, 32'h0000_A5C3, 16, 1'b1);
        send_slot(1'b1, 32'h0000_0F0F, 16, 1'b0);
        idle(8);
        n_cmp++; if (recs.size() !== base + 2) begin n_bad++; $display("FAIL std_count: got %0d words want 2", recs.size() - base); end
        n_cmp++; if (recs[base].d !== 16'hA5C3) begin n_bad++; $display("FAIL std_left_data: got %h want a5c3", recs[base].d); end
        n_cmp++; if (recs[base].r !== 1'b0) begin n_bad++; $display("FAIL std_left_right: got %b want 0", recs[base].r); end
        n_cmp++; if (recs[base].lat !== 32'd4) begin n_bad++; $display("FAIL std_left_latency: got %0d want 4", recs[base].lat); end
        n_cmp++; if (recs[base+1].d !== 16'h0F0F) begin n_bad++; $display("FAIL std_right_data: got %h want 0f0f", recs[base+1].d); end
        n_cmp++; if (recs[base+1].r !== 1'b1) begin n_bad++; $display("FAIL std_right_right: got %b want 1", recs[base+1].r); end
        n_cmp++; if (recs[base+1].lat !== 32'd4) begin n_bad++; $display("FAIL std_right_latency: got %0d want 4", recs[base+1].lat); end
        n_cmp++; if (err_seen !== e0) begin n_bad++; $display("FAIL std_no_err: got %0d errors want 0", err_seen - e0); end
        n_cmp++; if (bus.data_out !== 16'h0F0F) begin n_bad++; $display("FAIL std_hold: got %h want 0f0f", bus.data_out); end
    endtask

    task automatic test_wide_slot();
        int base;
        int e0;
        base = recs.size();
        e0   = err_seen;
        send_slot(1'b0, 32'h1234_FFFF, 32, 1'b1);
        send_slot(1'b1, 32'h8001_0000, 32, 1'b0);
        idle(8);
        n_cmp++; if (recs.size() !== base + 2) begin n_bad++; $display("FAIL wide_count: got %0d words want 2", recs.size() - base); end
        n_cmp++; if (recs[base].d !== 16'h1234) begin n_bad++; $display("FAIL wide_left_data: got %h want 1234", recs[base].d); end
        n_cmp++; if (recs[base].r !== 1'b0) begin n_bad++; $display("FAIL wide_left_right: got %b want 0", recs[base].r); end
        n_cmp++; if (recs[base+1].d !== 16'h8001) begin n_bad++; $display("FAIL wide_right_data: got %h want 8001", recs[base+1].d); end
        n_cmp++; if (recs[base+1].r !== 1'b1) begin n_bad++; $display("FAIL wide_right_right: got %b want 1", recs[base+1].r); end
        n_cmp++; if (err_seen !== e0) begin n_bad++; $display("FAIL wide_no_err: got %0d errors want 0", err_seen - e0); end
    endtask

    task automatic test_short_slot();
        int base;
        int e0;
        base = recs.size();
        e0   = err_seen;
        send_slot(1'b0, 32'h0000_02AB, 10, 1'b1);
        idle(8);
        n_cmp++; if (err_seen !== e0 + 1) begin n_bad++; $display("FAIL short_err_pulse: got %0d errors want 1", err_seen - e0); end
        n_cmp++; if (recs.size() !== base) begin n_bad++; $display("FAIL short_no_valid: got %0d words want 0", recs.size() - base); end
        send_slot(1'b1, 32'h0000_5A5A, 16, 1'b0);
        idle(8);
        n_cmp++; if (recs.size() !== base + 1) begin n_bad++; $display("FAIL short_next_count: got %0d words want 1", recs.size() - base); end
        n_cmp++; if (recs[base].d !== 16'h5A5A) begin n_bad++; $display("FAIL short_next_data: got %h want 5a5a", recs[base].d); end
        n_cmp++; if (recs[base].r !== 1'b1) begin n_bad++; $display("FAIL short_next_right: got %b want 1", recs[base].r); end
        n_cmp++; if (err_seen !== e0 + 1) begin n_bad++; $display("FAIL short_next_err: got %0d errors want 1", err_seen - e0); end
    endtask

    task automatic test_reset_mid_slot();
        int base;
        int e0;
        logic [15:0] w;
        w = 16'hBEEF;
        for (int i = 0; i < 7; i++) send_bit(1'b0, w[15-i]);
        idle(4);
        reset_n = 1'b0;
        #1;
        n_cmp++; if (bus.data_out !== 16'h0000) begin n_bad++; $display("FAIL midrst_data_out: got %h want 0000", bus.data_out); end
        n_cmp++; if (bus.data_right !== 1'b0) begin n_bad++; $display("FAIL midrst_data_right: got %b want 0", bus.data_right); end
        n_cmp++; if (bus.err_count !== 8'h00) begin n_bad++; $display("FAIL midrst_err_count: got %h want 00", bus.err_count); end
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        base = recs.size();
        e0   = err_seen;
        for (int i = 7; i < 15; i++) send_bit(1'b0, w[15-i]);
        send_bit(1'b1, w[0]);
        idle(8);
        n_cmp++; if (recs.size() !== base) begin n_bad++; $display("FAIL midrst_no_valid: got %0d words want 0", recs.size() - base); end
        n_cmp++; if (err_seen !== e0) begin n_bad++; $display("FAIL midrst_no_err: got %0d errors want 0", err_seen - e0); end
        send_slot(1'b1, 32'h0000_1357, 16, 1'b0);
        idle(8);
        n_cmp++; if (recs.size() !== base + 1) begin n_bad++; $display("FAIL midrst_count: got %0d words want 1", recs.size() - base); end
        n_cmp++; if (recs[base].d !== 16'h1357) begin n_bad++; $display("FAIL midrst_data: got %h want 1357", recs[base].d); end
        n_cmp++; if (recs[base].r !== 1'b1) begin n_bad++; $display("FAIL midrst_right: got %b want 1", recs[base].r); end
    endtask

    task automatic test_err_count();
        int base;
        int e0;
        logic ch;
        logic [7:0] want;
`ifdef I2S_RX_ERRCNT_EN
        want = 8'hFF;
`else
        want = 8'h00;
`endif
        base = recs.size();
        e0   = err_seen;
        ch   = 1'b0;
        for (int i = 0; i < 300; i++) begin
            send_slot(ch, 32'h0000_0002, 2, ~ch);
            ch = ~ch;
        end
        idle(8);
        n_cmp++; if (err_seen !== e0 + 300) begin n_bad++; $display("FAIL errcnt_pulses: got %0d errors want 300", err_seen - e0); end
        n_cmp++; if (recs.size() !== base) begin n_bad++; $display("FAIL errcnt_no_valid: got %0d words want 0", recs.size() - base); end
        n_cmp++; if (bus.err_count !== want) begin n_bad++; $display("FAIL errcnt_value: got %h want %h", bus.err_count, want); end
        for (int i = 0; i < 3; i++) begin
            send_slot(ch, 32'h0000_0001, 2, ~ch);
            ch = ~ch;
        end
        idle(8);
        n_cmp++; if (bus.err_count !== want) begin n_bad++; $display("FAIL errcnt_held: got %h want %h", bus.err_count, want); end
        n_cmp++; if (both_seen !== 0) begin n_bad++; $display("FAIL valid_err_exclusive: got %0d overlaps want 0", both_seen); end
    endtask

    initial begin
        bus.sclk = 1'b0;
        bus.ws   = 1'b0;
        bus.sd   = 1'b0;
        test_reset();
        test_presync();
        test_standard();
        test_wide_slot();
        test_short_slot();
        test_reset_mid_slot();
        test_err_count();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
